// File: rtl/sram_ctrl_arb2_if.sv
// Command/response channel between an SRAM requester and the controller side.
// Master issues commands and accepts responses; slave is the opposite end.
interface sram_ctrl_arb2_if #(
    parameter int unsigned DW = 64,
    parameter int unsigned AW = 16,
    parameter int unsigned MW = 8,
    parameter int unsigned UW = 2
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_read;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [MW-1:0] cmd_wmask;
    logic [UW-1:0] cmd_usr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [UW-1:0] rsp_usr;

    modport master (
        output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, cmd_usr, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_usr
    );

    modport slave (
        input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, cmd_usr, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_usr
    );
endinterface

// File: rtl/sram_ctrl_arb2.sv
// Round-robin two-requester arbiter in front of the SRAM controller command channel.
// Responses are steered back by the id bit carried in the top usr bit.
module sram_ctrl_arb2 #(
    parameter int unsigned DW       = 64,
    parameter int unsigned AW       = 16,
    parameter int unsigned MW       = 8,
    parameter int unsigned USR_W    = 2,
    parameter int unsigned MAX_OUTS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    sram_ctrl_arb2_if.slave  a,
    sram_ctrl_arb2_if.slave  b,
    sram_ctrl_arb2_if.master m,
    output logic             arb_active
);
    localparam int unsigned CW = $clog2(MAX_OUTS + 1);

    logic [CW-1:0]    out_cnt_q, out_cnt_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             rsp_fire, cmd_fire, cmd_en;
    logic             grant_a, grant_b, rsp_to_b;
    logic             sel_read;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;
    logic [MW-1:0]    sel_wmask;
    logic [USR_W-1:0] sel_usr;

    always_comb begin
        rsp_to_b    = m.rsp_usr[USR_W];
        m.rsp_ready = rsp_to_b ? b.rsp_ready : a.rsp_ready;
        a.rsp_valid = m.rsp_valid & ~rsp_to_b;
        b.rsp_valid = m.rsp_valid & rsp_to_b;
        a.rsp_rdata = m.rsp_rdata;
        b.rsp_rdata = m.rsp_rdata;
        a.rsp_usr   = m.rsp_usr[USR_W-1:0];
        b.rsp_usr   = m.rsp_usr[USR_W-1:0];
    end

    assign rsp_fire = m.rsp_valid & m.rsp_ready;

    always_comb begin
        // A same-cycle response frees a slot, so a full pipe still streams without bubbles.
        cmd_en  = (out_cnt_q < CW'(MAX_OUTS)) | rsp_fire;
        grant_b = b.cmd_valid & (~a.cmd_valid | rr_ptr_q);
        grant_a = a.cmd_valid & ~grant_b;

        sel_read  = grant_b ? b.cmd_read  : a.cmd_read;
        sel_addr  = grant_b ? b.cmd_addr  : a.cmd_addr;
        sel_wdata = grant_b ? b.cmd_wdata : a.cmd_wdata;
        sel_wmask = grant_b ? b.cmd_wmask : a.cmd_wmask;
        sel_usr   = grant_b ? b.cmd_usr   : a.cmd_usr;

        m.cmd_valid = cmd_en & (a.cmd_valid | b.cmd_valid);
        m.cmd_read  = sel_read;
        m.cmd_addr  = sel_addr;
        m.cmd_wdata = sel_wdata;
        m.cmd_wmask = sel_wmask;
        m.cmd_usr   = {grant_b, sel_usr};

        a.cmd_ready = cmd_en & grant_a & m.cmd_ready;
        b.cmd_ready = cmd_en & grant_b & m.cmd_ready;
        cmd_fire    = cmd_en & (a.cmd_valid | b.cmd_valid) & m.cmd_ready;
    end

    always_comb begin
        rr_ptr_d  = cmd_fire ? ~grant_b : rr_ptr_q;
        out_cnt_d = out_cnt_q;
        if (cmd_fire && !rsp_fire) begin
            out_cnt_d = out_cnt_q + CW'(1);
        end else if (!cmd_fire && rsp_fire && out_cnt_q != '0) begin
            out_cnt_d = out_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_cnt_q <= '0;
            rr_ptr_q  <= 1'b0;
        end else begin
            out_cnt_q <= out_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign arb_active = (out_cnt_q != '0) | a.cmd_valid | b.cmd_valid;

`ifndef SYNTHESIS
    // A response with nothing outstanding means the controller broke protocol.
    always_ff @(posedge clk) begin
        if (rst_n && m.rsp_valid) begin
            assert (out_cnt_q != '0);
        end
    end
`endif
endmodule

// File: doc/sram_ctrl_arb2.md
# sram_ctrl_arb2

Two-requester arbiter in front of the 1-cycle SRAM controller (ITCM/DTCM path), sharing a single controller command channel between requester A (LSU side) and requester B (IFU/external bus side). Round-robin grant on the command channel, requester ID appended as the top usr bit, and responses routed back to the correct requester from the returned usr bit. A registered outstanding-transaction counter bounds in-flight requests so the controller's response pipeline can never overflow.

## Interface
- DW, 64, data width
- AW, 16, byte address width
- MW, 8, write mask width (DW/8)
- USR_W, 2, per-requester usr width; controller side is USR_W+1
- MAX_OUTS, 2, maximum accepted-but-unresponded commands (1..7)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- a_cmd_valid / a_cmd_ready  in/out  1  requester A command handshake
- a_cmd_read  in  1  1=read, 0=write
- a_cmd_addr  in  AW  address
- a_cmd_wdata  in  DW  write data
- a_cmd_wmask  in  MW  write byte mask
- a_cmd_usr  in  USR_W  requester tag
- a_rsp_valid / a_rsp_ready  out/in  1  requester A response handshake
- a_rsp_rdata  out  DW  read data
- a_rsp_usr  out  USR_W  returned tag
- b_cmd_* / b_rsp_*  same as A  requester B
- m_cmd_valid / m_cmd_ready  out/in  1  controller command handshake
- m_cmd_read, m_cmd_addr, m_cmd_wdata, m_cmd_wmask  out  1/AW/DW/MW  muxed command
- m_cmd_usr  out  USR_W+1  {grant_id, usr}; grant_id 0=A, 1=B
- m_rsp_valid / m_rsp_ready  in/out  1  controller response handshake
- m_rsp_rdata  in  DW  read data
- m_rsp_usr  in  USR_W+1  returned {id, usr}
- arb_active  out  1  out_cnt!=0 or any cmd_valid; feeds clock-gating logic

## Operation
- State: rr_ptr (1 bit, requester preferred on conflict; reset 0 = A), out_cnt (clog2(MAX_OUTS+1) bits; reset 0).
- cmd_en = (out_cnt < MAX_OUTS) | rsp_fire, where rsp_fire = m_rsp_valid & m_rsp_ready.
- Grant: only A valid -> A; only B valid -> B; both -> rr_ptr. No valid -> no grant, m_cmd_valid=0.
- m_cmd_valid = cmd_en & (a_cmd_valid | b_cmd_valid); command fields and usr muxed from granted requester; when neither is valid, fields are driven from A (don't-care).
- a_cmd_ready = cmd_en & grant_A & m_cmd_ready; b_cmd_ready likewise. The non-granted requester sees ready=0.
- cmd_fire = m_cmd_valid & m_cmd_ready. On cmd_fire, rr_ptr <= ~grant_id (the loser of this cycle is preferred next); otherwise rr_ptr holds.
- out_cnt: +1 on cmd_fire only, -1 on rsp_fire only, unchanged when both or neither. Must never exceed MAX_OUTS or go below 0.
- Response routing by m_rsp_usr[USR_W]: 0 -> a_rsp_valid = m_rsp_valid, m_rsp_ready = a_rsp_ready; 1 -> B likewise. Unselected rsp_valid = 0. rdata and usr[USR_W-1:0] are broadcast to both ports.
- Writes produce a response like reads (controller behaviour); they are counted identically.
- rsp_valid with out_cnt==0 is a protocol error; pass through, hold counter at 0 (saturate), with a sim-only assertion.
- Reset mid-operation: out_cnt and rr_ptr return to 0 on the next clk edge regardless of in-flight traffic; the controller is reset by the same rst_n.

## Timing
- Zero-cycle arbitration: command path and response path are purely combinational; no added latency. Total latency equals the controller latency.
- Registered state updates on the clk rising edge following the fire.
- cmd_en counts a same-cycle response, so at MAX_OUTS a full-throughput stream (1 cmd + 1 rsp per cycle) sustains with no bubble.
- Requester ready depends combinationally on m_cmd_ready and m_rsp_ready/m_rsp_valid. No combinational path from x_cmd_valid to x_cmd_ready of the same requester, except through grant selection.
- Outputs after reset: all *_ready and *_valid are 0 unless inputs drive them combinationally; arb_active = 0 with idle inputs.

## Test plan
- Reset then A alone issues 4 back-to-back reads (usr=1,2,3,0), with m_cmd_ready=1 and the controller returning after 1 cycle -> m_cmd_usr = 3'b001,010,011,000; a_rsp_usr matches in order; b_rsp_valid never 1; out_cnt peaks at 1.
- A and B both continuously valid -> grants alternate A,B,A,B starting with A after reset; m_cmd_usr[2] toggles 0,1,0,1.
- MAX_OUTS=2, m_rsp_ready held 0 with the controller holding its response -> exactly 2 commands accepted, then a_cmd_ready=0 and m_cmd_valid=0; release rsp_ready -> a new command is accepted in the same cycle as the response fires.
- Interleaved responses id=1 then id=0 with b_rsp_ready=0 for 3 cycles -> m_rsp_ready=0 for those cycles, A's response is not delivered until B accepts, and data is unchanged.
- Simultaneous cmd_fire and rsp_fire for 10 cycles at out_cnt=1 -> out_cnt stays 1.
- Assert rst_n=0 with out_cnt=2 and rr_ptr=1 -> next cycle out_cnt=0, rr_ptr=0, arb_active=0.
